// File: rtl/risk_checks_mc_pkg.sv
// risk_checks_mc_pkg: shared reason codes, width defaults and helpers for the
// pre-trade risk gate.
package risk_checks_mc_pkg;

   typedef enum logic [2:0] {
      RSN_OK      = 3'd0,
      RSN_POS     = 3'd1,
      RSN_NOT     = 3'd2,
      RSN_GAP     = 3'd3,
      RSN_BADSYM  = 3'd4,
      RSN_ZEROQTY = 3'd5,
      RSN_KILL    = 3'd6
   } rsn_e;

   localparam int DEF_NUM_SYMS = 4;
   localparam int DEF_PRICE_W  = 32;
   localparam int DEF_SIZE_W   = 16;
   localparam int DEF_TS_W     = 32;

   // Symbol index width, never narrower than one bit.
   function automatic int sym_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/risk_checks_mc_sym_state.sv
// risk_sym_state: per-symbol register file holding position, gross notional,
// last-accept timestamp, seen flag and runtime limits. One combinational read
// port, one state write port (accepted orders), one limit write port.
module risk_sym_state
   import risk_checks_mc_pkg::*;
#(
   parameter int NUM_SYMS = DEF_NUM_SYMS,
   parameter int SYM_W    = sym_w(NUM_SYMS),
   parameter int SIZE_W   = DEF_SIZE_W,
   parameter int POS_W    = SIZE_W + 1,
   parameter int NOT_W    = DEF_PRICE_W + DEF_SIZE_W,
   parameter int TS_W     = DEF_TS_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SYM_W-1:0]  rd_sym,
   output logic [POS_W-1:0]  rd_pos,
   output logic [NOT_W-1:0]  rd_not,
   output logic [TS_W-1:0]   rd_ts,
   output logic              rd_seen,
   output logic [SIZE_W-1:0] rd_max_pos,
   output logic [NOT_W-1:0]  rd_max_not,
   output logic [TS_W-1:0]   rd_min_gap,
   input  logic              wr_en,
   input  logic [SYM_W-1:0]  wr_sym,
   input  logic [POS_W-1:0]  wr_pos,
   input  logic [NOT_W-1:0]  wr_not,
   input  logic [TS_W-1:0]   wr_ts,
   input  logic              cfg_we,
   input  logic [SYM_W-1:0]  cfg_sym,
   input  logic [SIZE_W-1:0] cfg_max_pos,
   input  logic [NOT_W-1:0]  cfg_max_not,
   input  logic [TS_W-1:0]   cfg_min_gap
);

   logic [NUM_SYMS-1:0][POS_W-1:0]  pos_q;
   logic [NUM_SYMS-1:0][NOT_W-1:0]  not_q;
   logic [NUM_SYMS-1:0][TS_W-1:0]   ts_q;
   logic [NUM_SYMS-1:0]             seen_q;
   logic [NUM_SYMS-1:0][SIZE_W-1:0] max_pos_q;
   logic [NUM_SYMS-1:0][NOT_W-1:0]  max_not_q;
   logic [NUM_SYMS-1:0][TS_W-1:0]   min_gap_q;

   // Entry updates: trading state on accepts, limits on cfg writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_q     <= '0;
         not_q     <= '0;
         ts_q      <= '0;
         seen_q    <= '0;
         max_pos_q <= '0;
         max_not_q <= '0;
         min_gap_q <= '0;
      end else begin
         for (int i = 0; i < NUM_SYMS; i++) begin
            if (wr_en && wr_sym == SYM_W'(i)) begin
               pos_q[i]  <= wr_pos;
               not_q[i]  <= wr_not;
               ts_q[i]   <= wr_ts;
               seen_q[i] <= 1'b1;
            end
            if (cfg_we && cfg_sym == SYM_W'(i)) begin
               max_pos_q[i] <= cfg_max_pos;
               max_not_q[i] <= cfg_max_not;
               min_gap_q[i] <= cfg_min_gap;
            end
         end
      end
   end

   // Read mux; an index with no entry reads back all zeros.
   always_comb begin
      rd_pos     = '0;
      rd_not     = '0;
      rd_ts      = '0;
      rd_seen    = 1'b0;
      rd_max_pos = '0;
      rd_max_not = '0;
      rd_min_gap = '0;
      for (int i = 0; i < NUM_SYMS; i++) begin
         if (rd_sym == SYM_W'(i)) begin
            rd_pos     = pos_q[i];
            rd_not     = not_q[i];
            rd_ts      = ts_q[i];
            rd_seen    = seen_q[i];
            rd_max_pos = max_pos_q[i];
            rd_max_not = max_not_q[i];
            rd_min_gap = min_gap_q[i];
         end
      end
   end

endmodule

// File: rtl/risk_checks_mc.sv
// risk_checks_mc: two-stage pre-trade risk gate. S1 registers the order and its
// value (price*qty); S2 reads symbol state, decides, updates state on accept and
// loads the verdict register. Optional kill switch under RISK_KILL_SWITCH_EN.
module risk_checks_mc
   import risk_checks_mc_pkg::*;
#(
   parameter int NUM_SYMS = DEF_NUM_SYMS,
   parameter int SYM_W    = sym_w(NUM_SYMS),
   parameter int PRICE_W  = DEF_PRICE_W,
   parameter int SIZE_W   = DEF_SIZE_W,
   parameter int POS_W    = SIZE_W + 1,
   parameter int NOT_W    = PRICE_W + SIZE_W,
   parameter int TS_W     = DEF_TS_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SYM_W-1:0]   in_sym,
   input  logic               in_side,
   input  logic [PRICE_W-1:0] in_price,
   input  logic [SIZE_W-1:0]  in_qty,
   input  logic [TS_W-1:0]    in_ts,
   input  logic               cfg_we,
   input  logic [SYM_W-1:0]   cfg_sym,
   input  logic [SIZE_W-1:0]  cfg_max_pos,
   input  logic [NOT_W-1:0]   cfg_max_not,
   input  logic [TS_W-1:0]    cfg_min_gap,
`ifdef RISK_KILL_SWITCH_EN
   input  logic               kill_set,
   input  logic               kill_clr,
   output logic               killed,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_accept,
   output logic [2:0]         out_reason,
   output logic [SYM_W-1:0]   out_sym,
   output logic               out_side,
   output logic [PRICE_W-1:0] out_price,
   output logic [SIZE_W-1:0]  out_qty,
   output logic [POS_W-1:0]   out_pos
);

   localparam logic [SYM_W:0] NSYM = (SYM_W+1)'(NUM_SYMS);

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = rst_n && adv;

   // S1 registers
   logic               s1_valid;
   logic [SYM_W-1:0]   s1_sym;
   logic               s1_side;
   logic [PRICE_W-1:0] s1_price;
   logic [SIZE_W-1:0]  s1_qty;
   logic [TS_W-1:0]    s1_ts;
   logic [NOT_W-1:0]   s1_val;

   // S1: capture order and its value whenever the pipe advances.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sym   <= '0;
         s1_side  <= 1'b0;
         s1_price <= '0;
         s1_qty   <= '0;
         s1_ts    <= '0;
         s1_val   <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_sym   <= in_sym;
         s1_side  <= in_side;
         s1_price <= in_price;
         s1_qty   <= in_qty;
         s1_ts    <= in_ts;
         s1_val   <= NOT_W'(in_price) * NOT_W'(in_qty);
      end
   end

   // Kill switch state
   logic kill_act;
`ifdef RISK_KILL_SWITCH_EN
   logic killed_q;
   // Set wins over clear when both arrive together.
   always_ff @(posedge clk) begin
      if (!rst_n)        killed_q <= 1'b0;
      else if (kill_set) killed_q <= 1'b1;
      else if (kill_clr) killed_q <= 1'b0;
   end
   assign kill_act = killed_q;
   assign killed   = killed_q;
`else
   assign kill_act = 1'b0;
`endif

   // Symbol state read in S2
   logic [POS_W-1:0]  rd_pos;
   logic [NOT_W-1:0]  rd_not;
   logic [TS_W-1:0]   rd_ts;
   logic              rd_seen;
   logic [SIZE_W-1:0] rd_max_pos;
   logic [NOT_W-1:0]  rd_max_not;
   logic [TS_W-1:0]   rd_min_gap;

   logic [POS_W:0]    pos_ext, qty_ext, pos_new, pos_abs;
   logic [NOT_W:0]    not_new;
   logic [TS_W-1:0]   ts_diff;
   rsn_e              dec_reason;
   logic              dec_accept;
   logic              wr_en;

   // S2 decision: one extra bit on position/notional so nothing wraps into a pass.
   always_comb begin
      pos_ext    = {rd_pos[POS_W-1], rd_pos};
      qty_ext    = (POS_W+1)'(s1_qty);
      pos_new    = s1_side ? (pos_ext + qty_ext) : (pos_ext - qty_ext);
      pos_abs    = pos_new[POS_W] ? ((POS_W+1)'(0) - pos_new) : pos_new;
      not_new    = (NOT_W+1)'(rd_not) + (NOT_W+1)'(s1_val);
      ts_diff    = s1_ts - rd_ts;
      dec_reason = RSN_OK;
      if (kill_act)                                    dec_reason = RSN_KILL;
      else if ({1'b0, s1_sym} >= NSYM)                 dec_reason = RSN_BADSYM;
      else if (s1_qty == '0)                           dec_reason = RSN_ZEROQTY;
      else if (pos_abs > (POS_W+1)'(rd_max_pos))       dec_reason = RSN_POS;
      else if (not_new > (NOT_W+1)'(rd_max_not))       dec_reason = RSN_NOT;
      else if (rd_seen && (ts_diff < rd_min_gap))      dec_reason = RSN_GAP;
      dec_accept = (dec_reason == RSN_OK);
   end

   assign wr_en = adv && s1_valid && dec_accept;

   risk_sym_state #(
      .NUM_SYMS(NUM_SYMS), .SYM_W(SYM_W), .SIZE_W(SIZE_W),
      .POS_W(POS_W), .NOT_W(NOT_W), .TS_W(TS_W)
   ) u_state (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_sym     (s1_sym),
      .rd_pos     (rd_pos),
      .rd_not     (rd_not),
      .rd_ts      (rd_ts),
      .rd_seen    (rd_seen),
      .rd_max_pos (rd_max_pos),
      .rd_max_not (rd_max_not),
      .rd_min_gap (rd_min_gap),
      .wr_en      (wr_en),
      .wr_sym     (s1_sym),
      .wr_pos     (pos_new[POS_W-1:0]),
      .wr_not     (not_new[NOT_W-1:0]),
      .wr_ts      (s1_ts),
      .cfg_we     (cfg_we),
      .cfg_sym    (cfg_sym),
      .cfg_max_pos(cfg_max_pos),
      .cfg_max_not(cfg_max_not),
      .cfg_min_gap(cfg_min_gap)
   );

   // S2 output register: holds the verdict stable while downstream stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_accept <= 1'b0;
         out_reason <= '0;
         out_sym    <= '0;
         out_side   <= 1'b0;
         out_price  <= '0;
         out_qty    <= '0;
         out_pos    <= '0;
      end else if (adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_accept <= dec_accept;
            out_reason <= dec_reason;
            out_sym    <= s1_sym;
            out_side   <= s1_side;
            out_price  <= s1_price;
            out_qty    <= s1_qty;
            out_pos    <= dec_accept ? pos_new[POS_W-1:0] : rd_pos;
         end
      end
   end

endmodule
